addr_mode_seq: RTL and testbench

ADDR_MODE_SEQ -- requirements
Module: addr_mode_seq

---
 rtl/addr_mode_seq.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_addr_mode_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_mode_seq.sv
// addr_mode_seq: effective-address sequencer for 6502-style addressing modes.
// It resolves the effective address (EA) for IMM, ZPG, ZPG_X/Y, ABS, ABS_X/Y,
// IND_X and IND_Y. For loads it also fetches the operand over a simple
// request/acknowledge memory read port.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             decoded instruction valid (sampled only while idle)
//   mode_i, is_store_i  addressing mode and store flag
//   imm_i, x_i, y_i     operand bytes and index registers (sampled at accept)
//   mem_req_o/addr_o    read request and address, held until mem_ack_i
//   mem_ack_i/rdata_i   read completion and data
//   busy_o, done_o      sequence in progress / one-cycle completion pulse
//   ea_o, operand_o     effective address and fetched operand
//   page_cross_o        indexed EA landed in a different page than the base
//
// Configuration macro: ADDR_SEQ_PAGE_PENALTY_EN
//   When defined, a one-cycle PENALTY state is inserted for ABS_X, ABS_Y and
//   IND_Y. Loads take it only on a page cross; stores always take it.
//   When undefined, PENALTY is never entered.

module addr_mode_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  mode_i,
    input  logic        is_store_i,
    input  logic [15:0] imm_i,
    input  logic [7:0]  x_i,
    input  logic [7:0]  y_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] ea_o,
    output logic [7:0]  operand_o,
    output logic        page_cross_o
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned MW = 4;

`ifdef ADDR_SEQ_PAGE_PENALTY_EN
    localparam bit PenaltyEn = 1'b1;
`else
    localparam bit PenaltyEn = 1'b0;
`endif

    localparam logic [MW-1:0] M_IMM   = 4'd0;
    localparam logic [MW-1:0] M_ZPG   = 4'd1;
    localparam logic [MW-1:0] M_ZPG_X = 4'd2;
    localparam logic [MW-1:0] M_ZPG_Y = 4'd3;
    localparam logic [MW-1:0] M_ABS   = 4'd4;
    localparam logic [MW-1:0] M_ABS_X = 4'd5;
    localparam logic [MW-1:0] M_ABS_Y = 4'd6;
    localparam logic [MW-1:0] M_IND_X = 4'd7;
    localparam logic [MW-1:0] M_IND_Y = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE, S_PTR_LO, S_PTR_HI, S_PENALTY, S_READ, S_DONE
    } state_e;

    state_e state_q, state_d;

    // Working registers captured at accept or during pointer fetch.
    logic [MW-1:0] mode_q, mode_d;
    logic          store_q, store_d;
    logic [DW-1:0] y_q, y_d;
    logic [DW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [AW-1:0] ea_q, ea_d;
    logic          pc_q, pc_d;
    logic [DW-1:0] data_q, data_d;

    // Registered outputs.
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [AW-1:0] ea_out_q, ea_out_d;
    logic [DW-1:0] operand_q, operand_d;
    logic          page_cross_q, page_cross_d;

    // EA computed directly from the decoder inputs at accept.
    logic [AW-1:0] acc_ea_c;
    logic          acc_pc_c;
    logic [DW-1:0] acc_ptr_c;
    // EA formed from the fetched pointer bytes at the PTR_HI acknowledge.
    logic [AW-1:0] ind_base_c;
    logic [AW-1:0] ind_ea_c;
    logic          ind_pc_c;
    logic          enter_done_c;

    // IMM and the undefined modes above IND_Y complete without memory access.
    function automatic logic is_imm_class(input logic [MW-1:0] mode);
        return (mode == M_IMM) || (mode > M_IND_Y);
    endfunction

    // Where to go once the EA is known: optional penalty, then read or finish.
    function automatic state_e route_after_ea(input logic [MW-1:0] mode,
                                              input logic store,
                                              input logic pc);
        logic pen_mode;
        pen_mode = (mode == M_ABS_X) || (mode == M_ABS_Y) || (mode == M_IND_Y);
        if (PenaltyEn && pen_mode && (store || pc)) begin
            return S_PENALTY;
        end else if (store) begin
            return S_DONE;
        end else begin
            return S_READ;
        end
    endfunction

    // Accept-time address arithmetic; zero-page sums wrap within page zero.
    always_comb begin
        acc_ea_c  = imm_i;
        acc_pc_c  = 1'b0;
        acc_ptr_c = imm_i[7:0];
        case (mode_i)
            M_ZPG:   acc_ea_c = {8'h00, imm_i[7:0]};
            M_ZPG_X: acc_ea_c = {8'h00, DW'(imm_i[7:0] + x_i)};
            M_ZPG_Y: acc_ea_c = {8'h00, DW'(imm_i[7:0] + y_i)};
            M_ABS:   acc_ea_c = imm_i;
            M_ABS_X: begin
                acc_ea_c = AW'(imm_i + {8'h00, x_i});
                acc_pc_c = (acc_ea_c[15:8] != imm_i[15:8]);
            end
            M_ABS_Y: begin
                acc_ea_c = AW'(imm_i + {8'h00, y_i});
                acc_pc_c = (acc_ea_c[15:8] != imm_i[15:8]);
            end
            M_IND_X: acc_ptr_c = DW'(imm_i[7:0] + x_i);
            default: ;
        endcase
    end

    // Indirect EA: high byte arrives on mem_rdata_i in the PTR_HI ack cycle.
    always_comb begin
        ind_base_c = {mem_rdata_i, lo_q};
        ind_ea_c   = ind_base_c;
        ind_pc_c   = 1'b0;
        if (mode_q == M_IND_Y) begin
            ind_ea_c = AW'(ind_base_c + {8'h00, y_q});
            ind_pc_c = (ind_ea_c[15:8] != mem_rdata_i);
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (is_imm_class(mode_i)) begin
                        state_d = S_DONE;
                    end else if ((mode_i == M_IND_X) || (mode_i == M_IND_Y)) begin
                        state_d = S_PTR_LO;
                    end else begin
                        state_d = route_after_ea(mode_i, is_store_i, acc_pc_c);
                    end
                end
            end
            S_PTR_LO:  if (mem_ack_i) state_d = S_PTR_HI;
            S_PTR_HI:  if (mem_ack_i) state_d = route_after_ea(mode_q, store_q, ind_pc_c);
            S_PENALTY: state_d = store_q ? S_DONE : S_READ;
            S_READ:    if (mem_ack_i) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture at accept and at each read acknowledge.
    always_comb begin
        mode_d  = mode_q;
        store_d = store_q;
        y_d     = y_q;
        ptr_d   = ptr_q;
        lo_d    = lo_q;
        ea_d    = ea_q;
        pc_d    = pc_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    store_d = is_store_i;
                    y_d     = y_i;
                    ptr_d   = acc_ptr_c;
                    ea_d    = acc_ea_c;
                    pc_d    = acc_pc_c;
                    data_d  = imm_i[7:0];
                end
            end
            S_PTR_LO: if (mem_ack_i) lo_d = mem_rdata_i;
            S_PTR_HI: begin
                if (mem_ack_i) begin
                    ea_d = ind_ea_c;
                    pc_d = ind_pc_c;
                end
            end
            S_READ:   if (mem_ack_i) data_d = mem_rdata_i;
            default: ;
        endcase
    end

    // Output logic, decoded from the next state so outputs align with it.
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        mem_req_d    = (state_d == S_PTR_LO) || (state_d == S_PTR_HI) ||
                       (state_d == S_READ);
        mem_addr_d   = mem_addr_q;
        ea_out_d     = ea_out_q;
        operand_d    = operand_q;
        page_cross_d = page_cross_q;
        case (state_d)
            S_PTR_LO: mem_addr_d = {8'h00, ptr_d};
            S_PTR_HI: mem_addr_d = {8'h00, DW'(ptr_d + 8'd1)};
            S_READ:   mem_addr_d = ea_d;
            default: ;
        endcase
        enter_done_c = (state_d == S_DONE) && (state_q != S_DONE);
        if (enter_done_c) begin
            ea_out_d     = ea_d;
            page_cross_d = pc_d;
            // Stores keep the previous operand; only reads and IMM update it.
            if ((state_q == S_READ) || ((state_q == S_IDLE) && is_imm_class(mode_i))) begin
                operand_d = data_d;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q       <= '0;
            store_q      <= 1'b0;
            y_q          <= '0;
            ptr_q        <= '0;
            lo_q         <= '0;
            ea_q         <= '0;
            pc_q         <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            ea_out_q     <= '0;
            operand_q    <= '0;
            page_cross_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            store_q      <= store_d;
            y_q          <= y_d;
            ptr_q        <= ptr_d;
            lo_q         <= lo_d;
            ea_q         <= ea_d;
            pc_q         <= pc_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            ea_out_q     <= ea_out_d;
            operand_q    <= operand_d;
            page_cross_q <= page_cross_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign ea_o         = ea_out_q;
    assign operand_o    = operand_q;
    assign page_cross_o = page_cross_q;

endmodule

// File: tb/tb_addr_mode_seq.sv
// Scoreboard testbench for addr_mode_seq: directed transactions push expected
// completions; a monitor pops and checks them on every done_o pulse, and a
// memory model checks read addresses and address stability during waits.

module tb_addr_mode_seq;

    localparam logic [3:0] M_IMM   = 4'd0;
    localparam logic [3:0] M_ZPG   = 4'd1;
    localparam logic [3:0] M_ZPG_X = 4'd2;
    localparam logic [3:0] M_ZPG_Y = 4'd3;
    localparam logic [3:0] M_ABS   = 4'd4;
    localparam logic [3:0] M_ABS_X = 4'd5;
    localparam logic [3:0] M_ABS_Y = 4'd6;
    localparam logic [3:0] M_IND_X = 4'd7;
    localparam logic [3:0] M_IND_Y = 4'd8;

`ifdef ADDR_SEQ_PAGE_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  mode_i = '0;
    logic        is_store_i = 1'b0;
    logic [15:0] imm_i = '0;
    logic [7:0]  x_i = '0;
    logic [7:0]  y_i = '0;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  mem_rdata_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [15:0] ea_o;
    logic [7:0]  operand_o;
    logic        page_cross_o;

    addr_mode_seq dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .is_store_i   (is_store_i),
        .imm_i        (imm_i),
        .x_i          (x_i),
        .y_i          (y_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ea_o         (ea_o),
        .operand_o    (operand_o),
        .page_cross_o (page_cross_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          acc;
        int          lat;
        bit          chk_ea;
        logic [15:0] ea;
        logic [7:0]  op;
        logic        pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_addr_q[$];
    exp_t        e;
    logic [7:0]  mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int wait_cfg = 0;
    int wcnt = 0;
    bit last_wait = 1'b0;
    logic [15:0] last_addr = '0;
    logic [15:0] ea_addr;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every completion pulse is matched against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (done_o) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d, required no completion", cyc);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                if (e.chk_ea) chk({e.name, "_ea"}, 32'(ea_o), 32'(e.ea));
                chk({e.name, "_operand"}, 32'(operand_o), 32'(e.op));
                chk({e.name, "_page_cross"}, 32'(page_cross_o), 32'(e.pc));
            end
        end
    end

    // Memory model: acks after wait_cfg wait cycles, checks address order and stability.
    always @(negedge clk) begin
        if (mem_req_o) begin
            if (last_wait) chk("addr_stable", 32'(mem_addr_o), 32'(last_addr));
            if (wcnt >= wait_cfg) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem[mem_addr_o];
                wcnt        = 0;
                last_wait   = 1'b0;
                if (exp_addr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: got read at %04h, required no read", mem_addr_o);
                end else begin
                    ea_addr = exp_addr_q.pop_front();
                    chk("read_addr", 32'(mem_addr_o), 32'(ea_addr));
                end
            end else begin
                mem_ack_i = 1'b0;
                wcnt++;
                last_wait = 1'b1;
                last_addr = mem_addr_o;
            end
        end else begin
            mem_ack_i = 1'b0;
            wcnt      = 0;
            last_wait = 1'b0;
        end
    end

    task automatic run(input string name, input logic [3:0] mode, input logic st,
                       input logic [15:0] imm, input logic [7:0] x, input logic [7:0] y,
                       input int lat, input bit chk_ea, input logic [15:0] ea,
                       input logic [7:0] op, input logic pc, input int waitc,
                       input bit pulse_mid);
        exp_t ex;
        int   d0;
        @(negedge clk);
        wait_cfg   = waitc;
        start_i    = 1'b1;
        mode_i     = mode;
        is_store_i = st;
        imm_i      = imm;
        x_i        = x;
        y_i        = y;
        ex.name = name; ex.acc = cyc; ex.lat = lat; ex.chk_ea = chk_ea;
        ex.ea = ea; ex.op = op; ex.pc = pc;
        exp_q.push_back(ex);
        d0 = done_cnt;
        @(negedge clk);
        start_i = 1'b0;
        mode_i  = M_ZPG;
        imm_i   = 16'hDEAD;
        x_i     = 8'hEE;
        y_i     = 8'hEE;
        if (pulse_mid) begin
            @(negedge clk);
            start_i = 1'b1;
            mode_i  = M_IMM;
            imm_i   = 16'h00EE;
            @(negedge clk);
            start_i = 1'b0;
        end
        for (int i = 0; i < 50; i++) begin
            if (done_cnt != d0) break;
            @(negedge clk);
        end
        if (done_cnt == d0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done_o within 50 cycles, required done_o", name);
        end
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hA5;
        mem[16'h00FF] = 8'h34;
        mem[16'h0000] = 8'h12;
        mem[16'h1234] = 8'h5C;
        mem[16'h1300] = 8'h77;
        mem[16'h2010] = 8'hC3;
        mem[16'h0040] = 8'hF0;
        mem[16'h0041] = 8'h30;
        mem[16'h3110] = 8'h99;
        mem[16'h0001] = 8'h3C;
        mem[16'h4321] = 8'hE7;

        // Reset values, sampled while reset is still asserted.
        repeat (3) @(negedge clk);
        chk("rst_busy",       32'(busy_o), 32'd0);
        chk("rst_done",       32'(done_o), 32'd0);
        chk("rst_mem_req",    32'(mem_req_o), 32'd0);
        chk("rst_mem_addr",   32'(mem_addr_o), 32'd0);
        chk("rst_ea",         32'(ea_o), 32'd0);
        chk("rst_operand",    32'(operand_o), 32'd0);
        chk("rst_page_cross", 32'(page_cross_o), 32'd0);
        rst_i = 1'b0;

        run("imm", M_IMM, 1'b0, 16'h0042, 8'h00, 8'h00, 1, 1'b0, 16'h0000, 8'h42, 1'b0, 0, 1'b0);

        exp_addr_q.push_back(16'h0010);
        run("zpg_x_load", M_ZPG_X, 1'b0, 16'h00F0, 8'h20, 8'h00, 2, 1'b1, 16'h0010, 8'hA5, 1'b0, 0, 1'b0);

        exp_addr_q.push_back(16'h00FF);
        exp_addr_q.push_back(16'h0000);
        exp_addr_q.push_back(16'h1234);
        run("ind_x_load", M_IND_X, 1'b0, 16'h00FE, 8'h01, 8'h00, 4, 1'b1, 16'h1234, 8'h5C, 1'b0, 0, 1'b0);

        exp_addr_q.push_back(16'h1300);
        run("abs_y_load", M_ABS_Y, 1'b0, 16'h12FF, 8'h00, 8'h01, 2 + PEN, 1'b1, 16'h1300, 8'h77, 1'b1, 0, 1'b0);

        exp_addr_q.push_back(16'h2010);
        run("abs_x_wait", M_ABS_X, 1'b0, 16'h2000, 8'h10, 8'h00, 5, 1'b1, 16'h2010, 8'hC3, 1'b0, 3, 1'b1);

        exp_addr_q.push_back(16'h0040);
        exp_addr_q.push_back(16'h0041);
        exp_addr_q.push_back(16'h3110);
        run("ind_y_load", M_IND_Y, 1'b0, 16'h0040, 8'h00, 8'h20, 4 + PEN, 1'b1, 16'h3110, 8'h99, 1'b1, 0, 1'b0);

        run("zpg_store", M_ZPG, 1'b1, 16'h0080, 8'h00, 8'h00, 1, 1'b1, 16'h0080, 8'h99, 1'b0, 0, 1'b0);
        run("abs_x_store", M_ABS_X, 1'b1, 16'h10F0, 8'h20, 8'h00, 1 + PEN, 1'b1, 16'h1110, 8'h99, 1'b1, 0, 1'b0);

        exp_addr_q.push_back(16'h0001);
        run("zpg_y_load", M_ZPG_Y, 1'b0, 16'h00FF, 8'h00, 8'h02, 2, 1'b1, 16'h0001, 8'h3C, 1'b0, 0, 1'b0);

        run("mode9", 4'd9, 1'b0, 16'h00AB, 8'h00, 8'h00, 1, 1'b0, 16'h0000, 8'hAB, 1'b0, 0, 1'b0);

        // Reset during PTR_HI: the ack in the reset cycle and a start are both dropped.
        exp_addr_q.push_back(16'h00FF);
        exp_addr_q.push_back(16'h0000);
        @(negedge clk);
        wait_cfg   = 0;
        start_i    = 1'b1;
        mode_i     = M_IND_X;
        is_store_i = 1'b0;
        imm_i      = 16'h00FE;
        x_i        = 8'h01;
        d0 = done_cnt;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_o && (mem_addr_o == 16'h0000)) break;
            @(negedge clk);
        end
        chk("ptr_hi_reached", 32'(mem_addr_o), 32'h0000);
        rst_i   = 1'b1;
        start_i = 1'b1;
        mode_i  = M_IMM;
        imm_i   = 16'h0055;
        @(negedge clk);
        chk("midrst_busy",    32'(busy_o), 32'd0);
        chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
        chk("midrst_done",    32'(done_o), 32'd0);
        rst_i   = 1'b0;
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        chk("midrst_ea",      32'(ea_o), 32'd0);
        chk("midrst_operand", 32'(operand_o), 32'd0);

        exp_addr_q.push_back(16'h4321);
        run("abs_after_rst", M_ABS, 1'b0, 16'h4321, 8'h00, 8'h00, 2, 1'b1, 16'h4321, 8'hE7, 1'b0, 0, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("reads_all_seen",   32'(exp_addr_q.size()), 32'd0);
        chk("final_idle",       32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, required completion");
        $fatal(1);
    end

endmodule
